// File: rtl/samp_seq_pkg.sv
// Shared types and defaults for the sample sequencer (samp_seq) and its address counter.
package samp_seq_pkg;

    localparam int ADDR_WID_DEF = 10;
    localparam int SAMP_WID_DEF = 16;
    localparam int SAMP_CNT_WID = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STROBE,
        FETCH,
        PRESENT
    } state_t;

endpackage

// File: rtl/samp_addr_ctr.sv
// Waveform index counter: latches the sample count at run start and steps 0..nsamp_lat-1, wrapping.
module samp_addr_ctr
    import samp_seq_pkg::*;
#(
    parameter int ADDR_WID = ADDR_WID_DEF
) (
    input  logic                clk_tx,
    input  logic                rst_clk_tx,
    input  logic                latch_en,
    input  logic                clr_en,
    input  logic                adv_en,
    input  logic [ADDR_WID:0]   nsamp,
    output logic [ADDR_WID-1:0] index
);

    localparam logic [ADDR_WID:0] ONE = {{ADDR_WID{1'b0}}, 1'b1};

    logic [ADDR_WID:0] nsamp_lat;
    logic [ADDR_WID:0] last_idx;

    assign last_idx = nsamp_lat - ONE;

    // A zero-length waveform is treated as a single sample so the wrap point stays defined.
    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            nsamp_lat <= ONE;
            index     <= '0;
        end else begin
            if (latch_en) begin
                nsamp_lat <= (nsamp == '0) ? ONE : nsamp;
            end
            if (clr_en) begin
                index <= '0;
            end else if (adv_en) begin
                index <= ({1'b0, index} == last_idx) ? '0 : index + ADDR_WID'(1);
            end
        end
    end

endmodule

// File: rtl/samp_seq.sv
// Sample sequencer: steps through waveform RAM on each sample strobe and hands samples to the DAC serializer.
// Define SAMP_SEQ_DBG_CNT_EN to build the saturating handshake counter driving samp_cnt.
module samp_seq
    import samp_seq_pkg::*;
#(
    parameter int ADDR_WID = ADDR_WID_DEF,
    parameter int SAMP_WID = SAMP_WID_DEF,
    parameter int RAM_LAT  = 1
) (
    input  logic                    clk_tx,
    input  logic                    rst_clk_tx,
    input  logic                    en_clk_samp,
    input  logic                    samp_gen_go,
    input  logic [ADDR_WID:0]       nsamp,
    output logic [ADDR_WID-1:0]     ram_addr,
    output logic                    ram_rd_en,
    input  logic [SAMP_WID-1:0]     ram_dout,
    output logic [SAMP_WID-1:0]     samp,
    output logic                    samp_val,
    input  logic                    samp_rdy,
    output logic                    overrun,
    input  logic                    clr_overrun,
    output logic [SAMP_CNT_WID-1:0] samp_cnt
);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            lat_cnt;
    logic [ADDR_WID-1:0]   index;
    logic                  start;
    logic                  issue_rd;
    logic                  capture;
    logic                  adv_idx;
    logic                  set_ovr;
    logic                  xfer;

    assign xfer = samp_val & samp_rdy;

    samp_addr_ctr #(
        .ADDR_WID (ADDR_WID)
    ) u_addr_ctr (
        .clk_tx     (clk_tx),
        .rst_clk_tx (rst_clk_tx),
        .latch_en   (start),
        .clr_en     (start),
        .adv_en     (adv_idx),
        .nsamp      (nsamp),
        .index      (index)
    );

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe that finds the previous sample untaken still consumes its slot; one landing
    // while a fetch is in flight is dropped outright.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        issue_rd = 1'b0;
        capture  = 1'b0;
        adv_idx  = 1'b0;
        set_ovr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp_gen_go) begin
                    start   = 1'b1;
                    state_d = WAIT_STROBE;
                end
            end
            WAIT_STROBE: begin
                if (!samp_gen_go) begin
                    state_d = IDLE;
                end else if (en_clk_samp) begin
                    if (samp_val && !samp_rdy) begin
                        set_ovr = 1'b1;
                        adv_idx = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            FETCH: begin
                set_ovr = en_clk_samp;
                if (lat_cnt == 2'(RAM_LAT)) begin
                    capture = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                set_ovr = en_clk_samp;
                adv_idx = 1'b1;
                state_d = samp_gen_go ? WAIT_STROBE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            lat_cnt   <= '0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            samp      <= '0;
            samp_val  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            lat_cnt   <= (state_q == FETCH) ? lat_cnt + 2'd1 : 2'd0;
            ram_rd_en <= issue_rd;
            if (issue_rd) begin
                ram_addr <= index;
            end
            if (capture) begin
                samp     <= ram_dout;
                samp_val <= 1'b1;
            end else if (xfer) begin
                samp_val <= 1'b0;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SAMP_SEQ_DBG_CNT_EN
    logic [SAMP_CNT_WID-1:0] cnt_q;

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q != '1)) begin
            cnt_q <= cnt_q + SAMP_CNT_WID'(1);
        end
    end

    assign samp_cnt = cnt_q;
`else
    assign samp_cnt = '0;
`endif

endmodule
